processor_memory: RTL and testbench

- Responder end of the processor's memory and instruction interfaces: one word-addressed storage array serving two ports.
- Data port: the processor issues load/store requests; the block answers after a configurable number of wait states, using a req/ready handshake.
- Instruction port: returns the word at instructionAddress with a fixed 1-cycle registered latency.
- Sits beside the processor at top level and replaces the processor's bare memoryBus/instructionBus wiring with split read/write data.

---
 rtl/processor_mem_pkg.sv | 23 ++
 rtl/mem_array.sv | 34 +++
 rtl/processor_memory.sv | 132 +++++++++++++
 tb/tb_processor_memory.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/processor_mem_pkg.sv
// Shared definitions for the processor memory responder.
// Holds the data-port FSM state type, width constants, and the address range check
// used by both the data port and the instruction port.
package processor_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned BusAddrWidth = 32;

  // True when any address bit above the array index is set.
  function automatic logic addr_out_of_range(input logic [BusAddrWidth-1:0] addr,
                                             input int unsigned addr_width);
    logic [BusAddrWidth-1:0] hi;
    hi = addr >> addr_width;
    return hi != '0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Dual-port synchronous RAM, no reset on contents.
// Port A (read/write, read-before-write): a_en, a_we, a_addr, a_wdata -> a_rdata (registered,
//   updated only when a_en is set).
// Port B (read-only): b_addr -> b_rdata (registered every edge).
// A same-edge write on A and read on B at one index returns the old word on B.
module mem_array #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 a_en,
  input  logic                 a_we,
  input  logic [AddrWidth-1:0] a_addr,
  input  logic [DataWidth-1:0] a_wdata,
  output logic [DataWidth-1:0] a_rdata,
  input  logic [AddrWidth-1:0] b_addr,
  output logic [DataWidth-1:0] b_rdata
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata <= mem[a_addr];
      if (a_we) begin
        mem[a_addr] <= a_wdata;
      end
    end
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/processor_memory.sv
// Responder for the processor's data and instruction memory interfaces.
// Data port: memoryReq/memoryWE/memoryAddress/memoryWData in; memoryRData/memoryReady/
//   memoryError out. A request is accepted in IDLE, answered WAIT_STATES cycles later with a
//   one-cycle memoryReady pulse.
// Instruction port: instructionAddress in; instructionBus out, one-cycle registered latency.
// clk: rising-edge clock; reset: asynchronous, active-high.
module processor_memory
  import processor_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memoryReq,
  input  logic                    memoryWE,
  input  logic [BusAddrWidth-1:0] memoryAddress,
  input  logic [DATA_WIDTH-1:0]   memoryWData,
  output logic [DATA_WIDTH-1:0]   memoryRData,
  output logic                    memoryReady,
  output logic                    memoryError,
  input  logic [BusAddrWidth-1:0] instructionAddress,
  output logic [DATA_WIDTH-1:0]   instructionBus
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BusAddrWidth-1:0] addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic                    rdata_zero_q;
  logic                    ib_zero_q;

  logic                    accept, resp_entry;
  logic [BusAddrWidth-1:0] cur_addr;
  logic                    cur_we;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic                    cur_oor;
  logic [DATA_WIDTH-1:0]   a_rdata, b_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    resp_entry = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memoryReq) begin
          accept = 1'b1;
          cnt_d  = WaitInit;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            resp_entry = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          resp_entry = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the RESP-entry edge is the accept edge, so the live request
  // fields must feed the array instead of the (not yet loaded) capture registers.
  always_comb begin
    cur_addr  = (state_q == StIdle) ? memoryAddress : addr_q;
    cur_we    = (state_q == StIdle) ? memoryWE : we_q;
    cur_wdata = (state_q == StIdle) ? memoryWData : wdata_q;
    cur_oor   = addr_out_of_range(cur_addr, ADDR_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_zero_q <= 1'b1;
      ib_zero_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= memoryAddress;
        we_q    <= memoryWE;
        wdata_q <= memoryWData;
      end
      if (resp_entry) begin
        err_q        <= cur_oor;
        // Stores and out-of-range loads present zero read data.
        rdata_zero_q <= cur_we | cur_oor;
      end
      ib_zero_q <= addr_out_of_range(instructionAddress, ADDR_WIDTH);
    end
  end

  mem_array #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_mem_array (
    .clk    (clk),
    .a_en   (resp_entry & ~cur_oor),
    .a_we   (cur_we),
    .a_addr (cur_addr[ADDR_WIDTH-1:0]),
    .a_wdata(cur_wdata),
    .a_rdata(a_rdata),
    .b_addr (instructionAddress[ADDR_WIDTH-1:0]),
    .b_rdata(b_rdata)
  );

  // The zero flags are registered alongside the RAM outputs, so both outputs stay
  // registered while still reading 0 immediately on reset.
  assign memoryReady    = (state_q == StResp);
  assign memoryError    = err_q;
  assign memoryRData    = rdata_zero_q ? '0 : a_rdata;
  assign instructionBus = ib_zero_q ? '0 : b_rdata;

endmodule

// File: tb/tb_processor_memory.sv
// Directed bench for processor_memory: three instances with WAIT_STATES of 2, 0 and 3
// share one clock and reset; index 0/1/2 selects the instance in the helper tasks.
module tb_processor_memory;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] maddr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic [31:0] iaddr [3];
  logic [31:0] ibus  [3];

  int n_cmp = 0;
  int n_err = 0;

  processor_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .reset(rst), .memoryReq(req[0]), .memoryWE(we[0]), .memoryAddress(maddr[0]),
    .memoryWData(wdata[0]), .memoryRData(rdata[0]), .memoryReady(ready[0]),
    .memoryError(err[0]), .instructionAddress(iaddr[0]), .instructionBus(ibus[0])
  );

  processor_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(rst), .memoryReq(req[1]), .memoryWE(we[1]), .memoryAddress(maddr[1]),
    .memoryWData(wdata[1]), .memoryRData(rdata[1]), .memoryReady(ready[1]),
    .memoryError(err[1]), .instructionAddress(iaddr[1]), .instructionBus(ibus[1])
  );

  processor_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(3)) dut_w3 (
    .clk(clk), .reset(rst), .memoryReq(req[2]), .memoryWE(we[2]), .memoryAddress(maddr[2]),
    .memoryWData(wdata[2]), .memoryRData(rdata[2]), .memoryReady(ready[2]),
    .memoryError(err[2]), .instructionAddress(iaddr[2]), .instructionBus(ibus[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One data-port transaction on instance d. Request raised at a negedge, accepted on the next
  // posedge; lat counts posedges after acceptance until ready is seen (99 on timeout). The
  // request is held until ready unless early_drop, in which case it falls one cycle after
  // acceptance. Returns one negedge after the ready cycle, having checked the pulse ended.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input bit early_drop, output logic [31:0] rd, output logic er,
                     output int lat, output logic [31:0] ib);
    bit seen;
    @(negedge clk);
    req[d]   = 1'b1;
    we[d]    = w;
    maddr[d] = a;
    wdata[d] = wd;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (early_drop) req[d] = 1'b0;
      if (ready[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) lat = 99;
    rd     = rdata[d];
    er     = err[d];
    ib     = ibus[d];
    req[d] = 1'b0;
    @(negedge clk);
    check($sformatf("ready_pulse_end[%0d]", d), 32'(ready[d]), 32'd0);
  endtask

  task automatic count_ready(input int d, input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) pulses++;
    end
  endtask

  logic [31:0] rd, ib;
  logic        er;
  int          lat, pulses;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; maddr[d] = '0; wdata[d] = '0; iaddr[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_error", 32'(err[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_ibus", ibus[0], 32'd0);
    rst = 1'b0;

    // WAIT_STATES=2: store then load address 5.
    txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, rd, er, lat, ib);
    check("w2_store_lat", 32'(lat), 32'd2);
    check("w2_store_err", 32'(er), 32'd0);
    check("w2_store_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'd5, 32'h0, 1'b0, rd, er, lat, ib);
    check("w2_load_lat", 32'(lat), 32'd2);
    check("w2_load_data", rd, 32'hDEADBEEF);
    check("w2_load_err", 32'(er), 32'd0);

    // WAIT_STATES=0: alternating store/load at addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b1, 32'(i), 32'hA500_0000 + 32'(i * 17), 1'b0, rd, er, lat, ib);
      check($sformatf("w0_store_lat[%0d]", i), 32'(lat), 32'd0);
      txn(1, 1'b0, 32'(i), 32'h0, 1'b0, rd, er, lat, ib);
      check($sformatf("w0_load_lat[%0d]", i), 32'(lat), 32'd0);
      check($sformatf("w0_load_data[%0d]", i), rd, 32'hA500_0000 + 32'(i * 17));
    end

    // Out-of-range accesses on WAIT_STATES=2.
    txn(0, 1'b1, 32'd1, 32'hCAFE0001, 1'b0, rd, er, lat, ib);
    txn(0, 1'b0, 32'h0000_0400, 32'h0, 1'b0, rd, er, lat, ib);
    check("oor_load_data", rd, 32'd0);
    check("oor_load_err", 32'(er), 32'd1);
    check("oor_load_lat", 32'(lat), 32'd2);
    check("oor_err_one_cycle", 32'(ready[0]), 32'd0);
    txn(0, 1'b1, 32'h8000_0001, 32'h0BAD_0BAD, 1'b0, rd, er, lat, ib);
    check("oor_store_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'd1, 32'h0, 1'b0, rd, er, lat, ib);
    check("oor_store_dropped", rd, 32'hCAFE0001);
    check("in_range_err_clear", 32'(er), 32'd0);

    // Store commit and fetch of address 7 on the same edge: fetch sees the old word.
    txn(0, 1'b1, 32'd7, 32'h0000_7777, 1'b0, rd, er, lat, ib);
    iaddr[0] = 32'd7;
    txn(0, 1'b1, 32'd7, 32'h0000_1234, 1'b0, rd, er, lat, ib);
    check("collision_old_word", ib, 32'h0000_7777);
    check("collision_new_word", ibus[0], 32'h0000_1234);
    iaddr[0] = 32'h0000_0407;
    @(negedge clk);
    check("fetch_oor_zero", ibus[0], 32'd0);

    // WAIT_STATES=3: request dropped one cycle after acceptance.
    txn(2, 1'b1, 32'd3, 32'h0000_0033, 1'b1, rd, er, lat, ib);
    check("drop_lat", 32'(lat), 32'd3);
    count_ready(2, 8, pulses);
    check("drop_no_second_txn", 32'(pulses), 32'd0);
    txn(2, 1'b0, 32'd3, 32'h0, 1'b0, rd, er, lat, ib);
    check("drop_data_committed", rd, 32'h0000_0033);

    // Reset in WAIT aborts a store to address 9.
    txn(0, 1'b1, 32'd9, 32'h0000_5555, 1'b0, rd, er, lat, ib);
    txn(0, 1'b0, 32'd5, 32'h0, 1'b0, rd, er, lat, ib);
    iaddr[0] = 32'd5;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; maddr[0] = 32'd9; wdata[0] = 32'h0000_AAAA;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    check("pre_rst_rdata_held", rdata[0], 32'hDEADBEEF);
    check("pre_rst_ibus", ibus[0], 32'hDEADBEEF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rdata", rdata[0], 32'd0);
    check("async_rst_ibus", ibus[0], 32'd0);
    check("async_rst_ready", 32'(ready[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_ready(0, 6, pulses);
    check("rst_no_ready_pulse", 32'(pulses), 32'd0);
    txn(0, 1'b0, 32'd9, 32'h0, 1'b0, rd, er, lat, ib);
    check("rst_store_aborted", rd, 32'h0000_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
